// File: rtl/otbn_pq_pkg.sv
// Shared types and index helpers for the PQ butterfly datapath.
// Pure definitions: no latency, no flow control.
package otbn_pq_pkg;

    localparam int unsigned PqWlen        = 256;
    localparam int unsigned PqLen         = 32;
    localparam int unsigned PqCoeffIdxW   = 8;
    localparam int unsigned PqWordsPerWdr = PqWlen / PqLen;
    localparam int unsigned PqTwIdxW      = 8;

    typedef enum logic [1:0] {
        BfSeqIdle,
        BfSeqRun,
        BfSeqDone
    } bf_seq_state_e;

    typedef struct packed {
        logic [4:0] wdr;
        logic [2:0] w_sel;
    } bf_loc_t;

    typedef struct packed {
        logic [4:0]          wdr_a;
        logic [2:0]          w_sel_a;
        logic [4:0]          wdr_b;
        logic [2:0]          w_sel_b;
        logic [PqTwIdxW-1:0] tw_idx;
        logic                tw_update;
        logic                last;
    } bf_cmd_t;

    // Coefficient index -> (WDR, word); the WDR index wraps mod 32 by design.
    function automatic bf_loc_t coeff_to_wdr_word(input logic [4:0]             wdr_base,
                                                  input logic [PqCoeffIdxW-1:0] idx,
                                                  input int unsigned            wsel_w);
        bf_loc_t                loc;
        logic [PqCoeffIdxW-1:0] word_mask;
        word_mask = PqCoeffIdxW'((1 << wsel_w) - 1);
        loc.wdr   = wdr_base + 5'(idx >> wsel_w);
        loc.w_sel = 3'(idx & word_mask);
        return loc;
    endfunction

endpackage

// File: rtl/otbn_pq_bf_seq.sv
// Walks all butterfly pairs of one NTT/INTT layer and issues one command per cycle.
// Latency: first command 1 cycle after start; registered outputs. Holds command while !bf_ready_i.
// Backpressure: k only advances on valid&&ready; abort wins over everything.
module otbn_pq_bf_seq
    import otbn_pq_pkg::*;
#(
    parameter int unsigned PQLEN   = 32,
    parameter int unsigned LogNMax = 8,
    parameter int unsigned TwIdxW  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [3:0]        log_n_i,
    input  logic [3:0]        log_len_i,
    input  logic [4:0]        wdr_base_i,
    input  logic [TwIdxW-1:0] tw_base_i,
    output logic              bf_valid_o,
    input  logic              bf_ready_i,
    output logic [4:0]        wdr_a_o,
    output logic [2:0]        w_sel_a_o,
    output logic [4:0]        wdr_b_o,
    output logic [2:0]        w_sel_b_o,
    output logic [TwIdxW-1:0] tw_idx_o,
    output logic              tw_update_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o
);

    localparam int unsigned WselW = $clog2(PqWlen / PQLEN);

    bf_seq_state_e          state_q;
    logic [PqCoeffIdxW-1:0] k_q;
    logic [3:0]             log_n_q;
    logic [3:0]             log_len_q;
    logic [4:0]             wdr_base_q;
    logic [TwIdxW-1:0]      tw_base_q;
    bf_cmd_t                cmd_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   cfg_err_q;
    logic                   cfg_legal;

    assign cfg_legal = (log_n_i != 4'd0) && ({28'd0, log_n_i} <= LogNMax) &&
                       (log_len_i < log_n_i);

    // Command for butterfly k: pairs (j, j+len) inside group k>>log_len.
    function automatic bf_cmd_t make_cmd(input logic [PqCoeffIdxW-1:0] k,
                                         input logic [3:0]             ln,
                                         input logic [3:0]             ll,
                                         input logic [4:0]             wb,
                                         input logic [TwIdxW-1:0]      tb);
        bf_cmd_t                cmd;
        logic [PqCoeffIdxW-1:0] len;
        logic [PqCoeffIdxW-1:0] group;
        logic [PqCoeffIdxW-1:0] pos;
        logic [PqCoeffIdxW-1:0] idx_a;
        logic [PqCoeffIdxW-1:0] idx_b;
        logic [PqCoeffIdxW-1:0] half;
        logic [TwIdxW-1:0]      tw;
        bf_loc_t                loc_a;
        bf_loc_t                loc_b;
        len   = PqCoeffIdxW'(1) << ll;
        group = k >> ll;
        pos   = k & (len - PqCoeffIdxW'(1));
        idx_a = (group << (ll + 4'd1)) | pos;
        idx_b = idx_a + len;
        half  = PqCoeffIdxW'(1) << (ln - 4'd1);
        tw    = tb + TwIdxW'(group);
        loc_a = coeff_to_wdr_word(wb, idx_a, WselW);
        loc_b = coeff_to_wdr_word(wb, idx_b, WselW);
        cmd.wdr_a     = loc_a.wdr;
        cmd.w_sel_a   = loc_a.w_sel;
        cmd.wdr_b     = loc_b.wdr;
        cmd.w_sel_b   = loc_b.w_sel;
        cmd.tw_idx    = PqTwIdxW'(tw);
        cmd.tw_update = (pos == '0);
        cmd.last      = (k == half - PqCoeffIdxW'(1));
        return cmd;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= BfSeqIdle;
            k_q        <= '0;
            log_n_q    <= '0;
            log_len_q  <= '0;
            wdr_base_q <= '0;
            tw_base_q  <= '0;
            cmd_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (abort_i) begin
                state_q <= BfSeqIdle;
                k_q     <= '0;
                cmd_q   <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    BfSeqIdle: begin
                        if (start_i && cfg_legal) begin
                            state_q    <= BfSeqRun;
                            k_q        <= '0;
                            log_n_q    <= log_n_i;
                            log_len_q  <= log_len_i;
                            wdr_base_q <= wdr_base_i;
                            tw_base_q  <= tw_base_i;
                            cmd_q      <= make_cmd('0, log_n_i, log_len_i, wdr_base_i, tw_base_i);
                            valid_q    <= 1'b1;
                            busy_q     <= 1'b1;
                        end else if (start_i) begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                    BfSeqRun: begin
                        if (valid_q && bf_ready_i) begin
                            if (cmd_q.last) begin
                                state_q <= BfSeqDone;
                                k_q     <= '0;
                                cmd_q   <= '0;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                k_q   <= k_q + PqCoeffIdxW'(1);
                                cmd_q <= make_cmd(k_q + PqCoeffIdxW'(1), log_n_q, log_len_q,
                                                  wdr_base_q, tw_base_q);
                            end
                        end
                    end
                    BfSeqDone: state_q <= BfSeqIdle;
                    default:   state_q <= BfSeqIdle;
                endcase
            end
        end
    end

    assign bf_valid_o  = valid_q;
    assign wdr_a_o     = cmd_q.wdr_a;
    assign w_sel_a_o   = cmd_q.w_sel_a;
    assign wdr_b_o     = cmd_q.wdr_b;
    assign w_sel_b_o   = cmd_q.w_sel_b;
    assign tw_idx_o    = TwIdxW'(cmd_q.tw_idx);
    assign tw_update_o = cmd_q.tw_update;
    assign last_o      = cmd_q.last;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_otbn_pq_bf_seq.sv
// Directed bench for otbn_pq_bf_seq: table of expected commands per layer plus
// hand-written sequences for illegal start, abort and asynchronous reset.
module tb_otbn_pq_bf_seq;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [3:0] log_n_i = '0;
    logic [3:0] log_len_i = '0;
    logic [4:0] wdr_base_i = '0;
    logic [7:0] tw_base_i = '0;
    logic       bf_valid_o;
    logic       bf_ready_i = 1'b0;
    logic [4:0] wdr_a_o;
    logic [2:0] w_sel_a_o;
    logic [4:0] wdr_b_o;
    logic [2:0] w_sel_b_o;
    logic [7:0] tw_idx_o;
    logic       tw_update_o;
    logic       last_o;
    logic       busy_o;
    logic       done_o;
    logic       cfg_err_o;

    int checks = 0;
    int failures = 0;

    otbn_pq_bf_seq #(.PQLEN(32), .LogNMax(8), .TwIdxW(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .log_n_i(log_n_i), .log_len_i(log_len_i), .wdr_base_i(wdr_base_i),
        .tw_base_i(tw_base_i), .bf_valid_o(bf_valid_o), .bf_ready_i(bf_ready_i),
        .wdr_a_o(wdr_a_o), .w_sel_a_o(w_sel_a_o), .wdr_b_o(wdr_b_o),
        .w_sel_b_o(w_sel_b_o), .tw_idx_o(tw_idx_o), .tw_update_o(tw_update_o),
        .last_o(last_o), .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    typedef struct {
        int         lid;
        logic [3:0] ln;
        logic [3:0] ll;
        logic [4:0] wb;
        logic [7:0] tb;
        int         stall_at;
        int         cmd_no;
        logic [4:0] wa;
        logic [2:0] sa;
        logic [4:0] wbx;
        logic [2:0] sb;
        logic [7:0] tw;
        logic       upd;
        logic       last;
    } vec_t;

    logic [25:0] cap [0:127];

    function automatic logic [25:0] cur_cmd();
        return {wdr_a_o, w_sel_a_o, wdr_b_o, w_sel_b_o, tw_idx_o, tw_update_o, last_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Runs one layer; ready drops for 3 cycles while command stall_at is presented.
    task automatic run_layer(input logic [3:0] ln, input logic [3:0] ll, input logic [4:0] wb,
                             input logic [7:0] tb, input int stall_at);
        int          n = 0;
        int          stalls = 0;
        int          cyc = 0;
        int          exp_cnt;
        logic [25:0] held = '0;
        exp_cnt    = 1 << (ln - 1);
        log_n_i    = ln;
        log_len_i  = ll;
        wdr_base_i = wb;
        tw_base_i  = tb;
        start_i    = 1'b1;
        bf_ready_i = 1'b1;
        step();
        start_i    = 1'b0;
        log_n_i    = '0;
        log_len_i  = '0;
        wdr_base_i = '0;
        tw_base_i  = '0;
        chk("start_latency_valid_busy", {30'd0, bf_valid_o, busy_o}, 32'd3);
        while (n < exp_cnt && cyc < 1000) begin
            if (!bf_valid_o) begin
                chk("valid_bubble", {31'd0, bf_valid_o}, 32'd1);
                break;
            end
            if (n == stall_at && stalls < 3) begin
                bf_ready_i = 1'b0;
                if (stalls == 0) held = cur_cmd();
                else chk("stall_hold", {6'd0, cur_cmd()}, {6'd0, held});
                stalls++;
            end else begin
                bf_ready_i = 1'b1;
                cap[n] = cur_cmd();
                n++;
            end
            step();
            cyc++;
        end
        chk("cmd_count", n, exp_cnt);
        chk("done_pulse_valid_busy", {29'd0, done_o, bf_valid_o, busy_o}, 32'd4);
        step();
        chk("done_one_cycle", {29'd0, done_o, bf_valid_o, busy_o}, 32'd0);
    endtask

    vec_t vecs [$];
    int   cur_lid;

    function automatic vec_t mk(int lid, logic [3:0] ln, logic [3:0] ll, logic [4:0] wb,
                                logic [7:0] tb, int stall_at, int cmd_no, logic [4:0] wa,
                                logic [2:0] sa, logic [4:0] wbx, logic [2:0] sb,
                                logic [7:0] tw, logic upd, logic last);
        vec_t v;
        v.lid = lid; v.ln = ln; v.ll = ll; v.wb = wb; v.tb = tb; v.stall_at = stall_at;
        v.cmd_no = cmd_no; v.wa = wa; v.sa = sa; v.wbx = wbx; v.sb = sb;
        v.tw = tw; v.upd = upd; v.last = last;
        return v;
    endfunction

    initial begin
        // len=4 over 8 coefficients in WDR 4, one group
        vecs.push_back(mk(0, 3, 2, 4, 10, -1, 0, 4, 0, 4, 4, 10, 1, 0));
        vecs.push_back(mk(0, 3, 2, 4, 10, -1, 1, 4, 1, 4, 5, 10, 0, 0));
        vecs.push_back(mk(0, 3, 2, 4, 10, -1, 2, 4, 2, 4, 6, 10, 0, 0));
        vecs.push_back(mk(0, 3, 2, 4, 10, -1, 3, 4, 3, 4, 7, 10, 0, 1));
        // len=1: four groups, twiddle advances every command
        vecs.push_back(mk(1, 3, 0, 0, 0, -1, 0, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 3, 0, 0, 0, -1, 1, 0, 2, 0, 3, 1, 1, 0));
        vecs.push_back(mk(1, 3, 0, 0, 0, -1, 2, 0, 4, 0, 5, 2, 1, 0));
        vecs.push_back(mk(1, 3, 0, 0, 0, -1, 3, 0, 6, 0, 7, 3, 1, 1));
        // N=256, len=128, WDR base 30 wraps
        vecs.push_back(mk(2, 8, 7, 30, 5, -1, 0, 30, 0, 14, 0, 5, 1, 0));
        vecs.push_back(mk(2, 8, 7, 30, 5, -1, 1, 30, 1, 14, 1, 5, 0, 0));
        vecs.push_back(mk(2, 8, 7, 30, 5, -1, 127, 13, 7, 29, 7, 5, 0, 1));
        // twiddle index wraps 255 -> 0
        vecs.push_back(mk(3, 2, 0, 31, 255, -1, 0, 31, 0, 31, 1, 255, 1, 0));
        vecs.push_back(mk(3, 2, 0, 31, 255, -1, 1, 31, 2, 31, 3, 0, 1, 1));
        // backpressure on command 2
        vecs.push_back(mk(4, 3, 2, 4, 10, 2, 0, 4, 0, 4, 4, 10, 1, 0));
        vecs.push_back(mk(4, 3, 2, 4, 10, 2, 1, 4, 1, 4, 5, 10, 0, 0));
        vecs.push_back(mk(4, 3, 2, 4, 10, 2, 2, 4, 2, 4, 6, 10, 0, 0));
        vecs.push_back(mk(4, 3, 2, 4, 10, 2, 3, 4, 3, 4, 7, 10, 0, 1));

        #2;
        chk("reset_outputs", {6'd0, bf_valid_o, busy_o, done_o, cfg_err_o, cur_cmd()}, 32'd0);
        #20;
        rst_ni = 1'b1;
        step();
        chk("idle_after_reset", {6'd0, bf_valid_o, busy_o, done_o, cfg_err_o, cur_cmd()}, 32'd0);

        cur_lid = -1;
        foreach (vecs[i]) begin
            if (vecs[i].lid != cur_lid) begin
                cur_lid = vecs[i].lid;
                run_layer(vecs[i].ln, vecs[i].ll, vecs[i].wb, vecs[i].tb, vecs[i].stall_at);
            end
            chk($sformatf("layer%0d_cmd%0d", vecs[i].lid, vecs[i].cmd_no),
                {6'd0, cap[vecs[i].cmd_no]},
                {6'd0, vecs[i].wa, vecs[i].sa, vecs[i].wbx, vecs[i].sb, vecs[i].tw,
                 vecs[i].upd, vecs[i].last});
        end

        // illegal configurations
        for (int t = 0; t < 3; t++) begin
            log_n_i   = (t == 0) ? 4'd3 : (t == 1) ? 4'd0 : 4'd9;
            log_len_i = (t == 0) ? 4'd3 : 4'd0;
            start_i   = 1'b1;
            step();
            start_i = 1'b0;
            chk($sformatf("illegal%0d_err", t), {29'd0, cfg_err_o, bf_valid_o, busy_o}, 32'd4);
            step();
            chk($sformatf("illegal%0d_clear", t), {29'd0, cfg_err_o, bf_valid_o, busy_o}, 32'd0);
        end

        // abort after two handshakes of an N=16, len=2 layer
        log_n_i    = 4'd4;
        log_len_i  = 4'd1;
        wdr_base_i = 5'd0;
        tw_base_i  = 8'd0;
        bf_ready_i = 1'b1;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        chk("abort_pre_cmd2", {6'd0, cur_cmd()}, {6'd0, 5'd0, 3'd4, 5'd0, 3'd6, 8'd1, 1'b1, 1'b0});
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_idle", {29'd0, bf_valid_o, busy_o, done_o}, 32'd0);
        step();
        chk("abort_no_done", {29'd0, bf_valid_o, busy_o, done_o}, 32'd0);
        run_layer(4'd4, 4'd1, 5'd0, 8'd0, -1);
        chk("restart_cmd0", {6'd0, cap[0]}, {6'd0, 5'd0, 3'd0, 5'd0, 3'd2, 8'd0, 1'b1, 1'b0});
        chk("restart_cmd7", {6'd0, cap[7]}, {6'd0, 5'd1, 3'd5, 5'd1, 3'd7, 8'd3, 1'b0, 1'b1});

        // asynchronous reset mid-layer
        log_n_i    = 4'd8;
        log_len_i  = 4'd7;
        wdr_base_i = 5'd3;
        tw_base_i  = 8'd9;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        chk("pre_reset_busy", {30'd0, bf_valid_o, busy_o}, 32'd3);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_reset", {6'd0, bf_valid_o, busy_o, done_o, cfg_err_o, cur_cmd()}, 32'd0);
        #10;
        rst_ni = 1'b1;
        step();
        chk("post_reset_idle", {29'd0, bf_valid_o, busy_o, done_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
